cordic_vectoring: RTL and testbench

Iterative CORDIC engine in vectoring mode, the inverse of the rotation path: it takes a Q3.29 vector (x, y) and returns its magnitude and its angle atan2(y, x). Each iteration drives y toward zero with shift-and-add micro-rotations and accumulates the applied angles. It sits beside the rotation-mode CORDIC unit and reuses the same `add_sub` adder and Q3.29 number format. Operands enter and results leave through valid/ready handshakes, one vector in flight at a time.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/add_sub.sv | 23 ++
 rtl/cordic_atan_lut.sv | 42 ++++
 rtl/cordic_vectoring.sv | 228 ++++++++++++++++++++++
 tb/tb_cordic_vectoring.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: definitions shared by the CORDIC units (rotation and vectoring).
// Holds the Q3.29 angle and gain constants, the supported ITER range and the
// engine FSM state type. There are no ports; the units import this package.
package cordic_pkg;

    localparam int CORDIC_N = 32;   // Q3.29 word width
    localparam int ITER_MIN = 8;
    localparam int ITER_MAX = 24;

    // Q3.29 constants
    localparam logic [31:0] Q_PI          = 32'h6487ED51;  // +pi
    localparam logic [31:0] Q_HALF_PI     = 32'h3243F6A9;  // +pi/2
    localparam logic [31:0] Q_NEG_HALF_PI = 32'hCDBC0957;  // -pi/2
    localparam logic [31:0] Q_INV_K       = 32'h136E9DB5;  // 1/K = 0.607252935

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_ROT  = 3'd2,
        ST_COMP = 3'd3,
        ST_DONE = 3'd4
    } cordic_state_e;

endpackage

// File: rtl/add_sub.sv
// add_sub: shared two's-complement adder/subtractor used by the CORDIC units.
// Ports: a, b  - operands (W bits)
//        a_s   - 1 selects a - b, 0 selects a + b
//        sum   - result (W bits, wraps)
module add_sub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         a_s,
    output logic [W-1:0] sum
);

    // Add or subtract as selected.
    always_comb begin
        if (a_s) begin
            sum = a - b;
        end else begin
            sum = a + b;
        end
    end

endmodule

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational table of atan(2^-i) in Q3.29, i = 0..23.
// Ports: idx      - iteration index i
//        atan_val - atan(2^-i) in Q3.29 (0 outside the table)
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [4:0]          idx,
    output logic [CORDIC_N-1:0] atan_val
);

    // From i = 10 on, atan(2^-i) rounds to exactly 2^(29-i).
    always_comb begin
        case (idx)
            5'd0:    atan_val = 32'd421657428;
            5'd1:    atan_val = 32'd248918915;
            5'd2:    atan_val = 32'd131521918;
            5'd3:    atan_val = 32'd66762579;
            5'd4:    atan_val = 32'd33510844;
            5'd5:    atan_val = 32'd16771758;
            5'd6:    atan_val = 32'd8387926;
            5'd7:    atan_val = 32'd4194219;
            5'd8:    atan_val = 32'd2097141;
            5'd9:    atan_val = 32'd1048575;
            5'd10:   atan_val = 32'd524288;
            5'd11:   atan_val = 32'd262144;
            5'd12:   atan_val = 32'd131072;
            5'd13:   atan_val = 32'd65536;
            5'd14:   atan_val = 32'd32768;
            5'd15:   atan_val = 32'd16384;
            5'd16:   atan_val = 32'd8192;
            5'd17:   atan_val = 32'd4096;
            5'd18:   atan_val = 32'd2048;
            5'd19:   atan_val = 32'd1024;
            5'd20:   atan_val = 32'd512;
            5'd21:   atan_val = 32'd256;
            5'd22:   atan_val = 32'd128;
            5'd23:   atan_val = 32'd64;
            default: atan_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC. It takes a Q3.29 vector
// (x, y) and returns its magnitude and atan2(y, x). One vector is in flight at
// a time.
// Ports: clk, rst_n (synchronous, active-low)
//        in_valid/in_ready, x_in, y_in      - operand handshake, Q3.29 inputs
//        out_valid/out_ready, mag_out, ang_out - result handshake, Q3.29 outputs
// Optional feature: defining CORDIC_GAIN_COMP_EN adds a COMP state that scales
// the magnitude by 1/K, so mag_out is the true magnitude. This costs one extra
// cycle. Without the macro, mag_out = K*|v|.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int N    = 32,
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] mag_out,
    output logic [N-1:0] ang_out
);

    // Two guard bits absorb gain growth (up to about 2.33) in x and y.
    localparam int         W      = N + 2;
    localparam logic [4:0] LAST_I = 5'(ITER - 1);

    if (ITER < ITER_MIN || ITER > ITER_MAX) begin : g_bad_iter
        $error("cordic_vectoring: ITER outside supported range");
    end

    cordic_state_e state_r, next_state_s;
    logic [W-1:0]  x_r, y_r;
    logic [N-1:0]  z_r;
    logic [4:0]    i_r;
    logic          zero_r;
    logic          in_ready_r, out_valid_r;
    logic [N-1:0]  mag_r, ang_r;

    logic          accept_s, last_iter_s, d_s, pre_zero_s;
    logic [W-1:0]  x_sh_s, y_sh_s, x_sum_s, y_sum_s, x_rot_s, y_rot_s;
    logic [N-1:0]  atan_s, z_sum_s, z_rot_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign mag_out   = mag_r;
    assign ang_out   = ang_r;

    assign accept_s    = in_valid && in_ready_r;
    assign last_iter_s = (i_r == LAST_I);
    assign pre_zero_s  = (x_r == '0) && (y_r == '0);
    assign d_s         = ~y_r[W-1];

    // Arithmetic shifts of the pre-update x and y by the iteration index.
    always_comb begin
        x_sh_s = $signed(x_r) >>> i_r;
        y_sh_s = $signed(y_r) >>> i_r;
    end

    cordic_atan_lut u_atan_lut (
        .idx      (i_r),
        .atan_val (atan_s)
    );

    // d=1 (y >= 0): x += y>>>i, y -= x>>>i, z += atan; d=0 flips all three.
    add_sub #(.W(W)) u_add_x (
        .a   (x_r),
        .b   (y_sh_s),
        .a_s (~d_s),
        .sum (x_sum_s)
    );

    add_sub #(.W(W)) u_add_y (
        .a   (y_r),
        .b   (x_sh_s),
        .a_s (d_s),
        .sum (y_sum_s)
    );

    add_sub #(.W(N)) u_add_z (
        .a   (z_r),
        .b   (atan_s),
        .a_s (~d_s),
        .sum (z_sum_s)
    );

    // The zero vector spends one inert ROT cycle with its state held.
    // That cycle sets the zero-vector latency, and the angle stays exactly 0.
    always_comb begin
        if (zero_r) begin
            x_rot_s = x_r;
            y_rot_s = y_r;
            z_rot_s = z_r;
        end else begin
            x_rot_s = x_sum_s;
            y_rot_s = y_sum_s;
            z_rot_s = z_sum_s;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int                  FRAC     = N - 3;
    localparam logic signed [W+N:0] RND_HALF = {{(W+N){1'b0}}, 1'b1} << (FRAC - 1);

    logic signed [W+N:0] prod_s;
    logic [W-1:0]        x_comp_s;

    // Multiply x by 1/K, then round to nearest back to Q3.29.
    always_comb begin
        prod_s   = $signed(x_r) * $signed({1'b0, Q_INV_K});
        x_comp_s = W'((prod_s + RND_HALF) >>> FRAC);
    end
`endif

    // Register the FSM state and the handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_PRE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRE: next_state_s = ST_ROT;
            ST_ROT: begin
                if (last_iter_s) begin
`ifdef CORDIC_GAIN_COMP_EN
                    next_state_s = ST_COMP;
`else
                    next_state_s = ST_DONE;
`endif
                end else begin
                    next_state_s = ST_ROT;
                end
            end
            ST_COMP: next_state_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, quadrant correction, iterations, result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            i_r    <= 5'd0;
            zero_r <= 1'b0;
            mag_r  <= '0;
            ang_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        x_r <= {{2{x_in[N-1]}}, x_in};
                        y_r <= {{2{y_in[N-1]}}, y_in};
                    end
                end
                ST_PRE: begin
                    zero_r <= pre_zero_s;
                    i_r    <= pre_zero_s ? LAST_I : 5'd0;
                    // For x < 0, rotate by -+90 deg into the right half plane.
                    // y = 0 takes the +90 deg branch, so the final angle is +pi.
                    if (x_r[W-1]) begin
                        if (!y_r[W-1]) begin
                            x_r <= y_r;
                            y_r <= -x_r;
                            z_r <= Q_HALF_PI;
                        end else begin
                            x_r <= -y_r;
                            y_r <= x_r;
                            z_r <= Q_NEG_HALF_PI;
                        end
                    end else begin
                        z_r <= '0;
                    end
                end
                ST_ROT: begin
                    x_r <= x_rot_s;
                    y_r <= y_rot_s;
                    z_r <= z_rot_s;
                    i_r <= i_r + 5'd1;
`ifndef CORDIC_GAIN_COMP_EN
                    if (last_iter_s) begin
                        mag_r <= x_rot_s[N-1:0];
                        ang_r <= z_rot_s;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                ST_COMP: begin
                    x_r   <= x_comp_s;
                    mag_r <= x_comp_s[N-1:0];
                    ang_r <= z_r;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: self-checking directed bench for cordic_vectoring.
// Expected results come from a real-valued model: magnitude is sqrt(x^2+y^2),
// scaled by K unless CORDIC_GAIN_COMP_EN is defined, and angle is atan2(y, x).
// Both are compared within 2^-14. Latency, hold, back-pressure and reset
// checks are exact.
`timescale 1ns/1ps
module tb_cordic_vectoring;

    localparam int     N     = 32;
    localparam int     ITER  = 16;
    localparam real    SCALE = 536870912.0;
    localparam longint TOL   = 64'sd32768;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int COMP_LAT = 1;
`else
    localparam int COMP_LAT = 0;
`endif
    localparam int LAT      = ITER + 1 + COMP_LAT;
    localparam int ZERO_LAT = 2 + COMP_LAT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] x_in = '0;
    logic [N-1:0] y_in = '0;
    logic         in_ready, out_valid;
    logic [N-1:0] mag_out, ang_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_vectoring #(.N(N), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out)
    );

    task automatic check_val(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic logic [N-1:0] to_q(input real r);
        return N'($rtoi(r * SCALE));
    endfunction

    function automatic real k_gain();
        real k;
        real p;
        k = 1.0;
        p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return k;
    endfunction

    function automatic longint exp_mag(input logic [N-1:0] xv, input logic [N-1:0] yv);
        real xr, yr, m;
        xr = $itor($signed(xv)) / SCALE;
        yr = $itor($signed(yv)) / SCALE;
        m  = $sqrt(xr * xr + yr * yr);
`ifndef CORDIC_GAIN_COMP_EN
        m = m * k_gain();
`endif
        return longint'($rtoi(m * SCALE));
    endfunction

    function automatic longint exp_ang(input logic [N-1:0] xv, input logic [N-1:0] yv);
        real xr, yr;
        xr = $itor($signed(xv)) / SCALE;
        yr = $itor($signed(yv)) / SCALE;
        return longint'($rtoi($atan2(yr, xr) * SCALE));
    endfunction

    // Present an operand and return #1 after the accepting edge.
    task automatic issue(input logic [N-1:0] xv, input logic [N-1:0] yv);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = xv;
        y_in = yv;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv);
        if (xv == '0 && yv == '0) begin
            check_val({tag, "_mag"}, longint'($signed(mag_out)), 64'sd0, 64'sd0);
            check_val({tag, "_ang"}, longint'($signed(ang_out)), 64'sd0, 64'sd0);
        end else begin
            check_val({tag, "_mag"}, longint'($signed(mag_out)), exp_mag(xv, yv), TOL);
            check_val({tag, "_ang"}, longint'($signed(ang_out)), exp_ang(xv, yv), TOL);
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_ov_drop"}, longint'(out_valid), 64'sd0, 64'sd0);
        check_val({tag, "_ir_back"}, longint'(in_ready), 64'sd1, 64'sd0);
    endtask

    task automatic run_op(input string tag, input logic [N-1:0] xv, input logic [N-1:0] yv, input int lat_exp);
        int lat;
        issue(xv, yv);
        wait_result(lat);
        check_val({tag, "_lat"}, longint'(lat), longint'(lat_exp), 64'sd0);
        check_res(tag, xv, yv);
        consume(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mag0, ang0;
        int lat;

        // Reset state, during and after reset.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ov", longint'(out_valid), 64'sd0, 64'sd0);
        check_val("rst_mag", longint'(mag_out), 64'sd0, 64'sd0);
        check_val("rst_ang", longint'(ang_out), 64'sd0, 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_ir", longint'(in_ready), 64'sd1, 64'sd0);

        // Main function over all quadrants plus boundaries.
        run_op("q45", 32'h10000000, 32'h10000000, LAT);
        run_op("negx", 32'hF0000000, 32'h00000000, LAT);
        check_val("negx_pi_pos", longint'(ang_out[N-1]), 64'sd0, 64'sd0);
        run_op("negy", 32'h00000000, to_q(-0.999), LAT);
        run_op("zero", 32'h00000000, 32'h00000000, ZERO_LAT);
        run_op("q3", to_q(-0.3), to_q(-0.4), LAT);
        run_op("q4", to_q(0.6), to_q(-0.2), LAT);
        run_op("q2", to_q(-0.7), to_q(0.1), LAT);
        run_op("small", to_q(0.001), to_q(0.002), LAT);

        // Back-pressure: results hold and a waiting operand is refused.
        issue(32'h10000000, 32'h10000000);
        wait_result(lat);
        check_val("hold_lat", longint'(lat), longint'(LAT), 64'sd0);
        mag0 = mag_out;
        ang0 = ang_out;
        @(negedge clk);
        in_valid = 1'b1;
        x_in = 32'hF0000000;
        y_in = 32'h00000000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check_val("hold_mag", longint'(mag_out), longint'(mag0), 64'sd0);
            check_val("hold_ang", longint'(ang_out), longint'(ang0), 64'sd0);
            check_val("hold_ov", longint'(out_valid), 64'sd1, 64'sd0);
            check_val("hold_ir", longint'(in_ready), 64'sd0, 64'sd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("hold_ov_drop", longint'(out_valid), 64'sd0, 64'sd0);
        check_val("hold_ir_back", longint'(in_ready), 64'sd1, 64'sd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("second_acc", longint'(in_ready), 64'sd0, 64'sd0);
        wait_result(lat);
        check_val("second_lat", longint'(lat), longint'(LAT), 64'sd0);
        check_res("second", 32'hF0000000, 32'h00000000);
        consume("second");

        // Reset in the middle of ROT aborts the operation.
        issue(to_q(0.3), to_q(0.2));
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_ov", longint'(out_valid), 64'sd0, 64'sd0);
        check_val("midrst_mag", longint'(mag_out), 64'sd0, 64'sd0);
        check_val("midrst_ang", longint'(ang_out), 64'sd0, 64'sd0);
        check_val("midrst_ir", longint'(in_ready), 64'sd1, 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (ITER + 4) @(posedge clk);
        #1;
        check_val("midrst_abort", longint'(out_valid), 64'sd0, 64'sd0);
        run_op("post_rst", to_q(-0.25), to_q(0.6), LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
